// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and baud-divider helpers.
// Used by both uart_transmitter and uart_receiver.
package uart_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // A one-clock bit period still needs a 1-bit counter to hold a legal vector.
  function automatic int unsigned cnt_width(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and occupancy count.
// Head entry is presented combinationally so a pop can consume it on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: bytes queue in a sync_fifo and are sent
// back-to-back, LSB first, with a registered idle-high serial output.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 460800,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] write_data,
  input  logic       write_req,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CW  = cnt_width(CPB);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  tx_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;

  logic           fifo_pop;
  logic [7:0]     fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           cnt_last;
  logic [CW-1:0]  cnt_next;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (write_req),
    .data_i  (write_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign ready    = !fifo_full;
  assign busy     = (state_q != TX_IDLE) || (fifo_count != '0);
  assign tx       = tx_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_next = cnt_last ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        cnt_d = cnt_next;
        if (cnt_last) state_d = TX_DATA;
      end
      TX_DATA: begin
        cnt_d = cnt_next;
        if (cnt_last) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        cnt_d = cnt_next;
        // Chain straight into the next frame so queued bytes leave no idle gap.
        if (cnt_last) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
            state_d  = TX_START;
          end else begin
            state_d  = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level follows the state one cycle later, keeping tx glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = data_q[bit_idx_q];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 460800, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide, truncating).
REQ-003 Parameter FIFO_DEPTH, default 16, byte queue depth; power of two, >= 2.
REQ-004 Port: clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: write_data  input  8  byte to transmit.
REQ-007 Port: write_req  input  1  enqueue write_data this cycle.
REQ-008 Port: ready  output  1  queue can accept a byte (not full).
REQ-009 Port: busy  output  1  queue non-empty or frame in progress.
REQ-010 Port: tx  output  1  serial line, idle high, registered.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-012 A byte SHALL be accepted on an edge where write_req && ready; write_req while !ready SHALL be dropped silently, with no state change.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when queue non-empty (pop into shift register on that edge); START->DATA, DATA (bit index 0..7)->STOP after bit 7, each after CLKS_PER_BIT cycles.
REQ-014 On the last STOP cycle: STOP->START with pop if queue non-empty (no idle gap between frames), else STOP->IDLE.
REQ-015 Latency: byte accepted at edge N into an empty queue while IDLE SHALL pop at edge N+1; tx SHALL be 0 after edge N+2.
REQ-016 Simultaneous push and pop SHALL leave occupancy unchanged; push while full is impossible by REQ-012.
REQ-017 ready SHALL equal (occupancy != FIFO_DEPTH), derived from registered state; it rises the cycle after a pop from full.
REQ-018 busy SHALL be low only when state is IDLE and the queue is empty; it falls after the last stop-bit cycle of the final frame.
REQ-019 Bit-cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide, wrapping to 0 at CLKS_PER_BIT-1; bit index SHALL be 3 bits.
REQ-020 write_data SHALL be captured in the queue; later changes to write_data SHALL not affect queued bytes.

Reset
REQ-021 On reset: tx=1, ready=1, busy=0, state=IDLE, counters=0, queue emptied.
REQ-022 Reset mid-frame SHALL abort the frame; tx SHALL be 1 after that edge; queued bytes are discarded.
REQ-023 write_req asserted together with reset SHALL be ignored.

Structure
REQ-024 Package uart_pkg SHALL hold the tx FSM state typedef and a clocks-per-bit function, shared with uart_receiver.
REQ-025 The queue SHALL be a sub-module sync_fifo (parameterised width and depth, synchronous active-high reset, push/pop/full/empty/count).
REQ-026 Top-level integration SHALL replace the CPU's direct uart_tx drive with this block at the clk (afi_clk) domain.

Verification (bench: CLK_FREQ=8, BAUD_RATE=1 -> 8 clks/bit, 80/frame)
REQ-027 Idle, write 0x55 at edge 0 -> tx 0 for edges 2..9, then 1,0,1,0,1,0,1,0 per 8 clks, stop 1; busy low after edge 81.
REQ-028 Write 18 bytes on edges 0..17 -> edges 0..16 accepted, ready low after edge 16, 18th dropped; 17 frames back-to-back, 1360 clks, no idle gap.
REQ-029 Queue full, pop at frame end -> ready high next cycle; a write then is accepted and sent after the queued bytes in order.
REQ-030 Reset during DATA bit 3 -> tx 1, ready 1, busy 0 after that edge; then write 0xA5 -> clean frame 0,1,0,1,0,0,1,0,1,1.
REQ-031 Write 0x00 then 0xFF -> tx low 72 clks, high 8 clks, low 8 clks, high 72 clks, then idle high.
